// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla_pipe_adder
// Description : WIDTH-bit pipelined carry-lookahead adder. Each stage resolves
//               WIDTH/STAGES bits and hands a registered carry to the next.
//               Optional A-B support is compiled in with CLA_PIPE_SUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SLICE_W = WIDTH / STAGES;
  localparam int GROUPS  = SLICE_W / 4;
  localparam int LAST    = STAGES - 1;

  // Per-stage registers. Operand registers hold the not-yet-added upper bits,
  // pre-shifted so the next slice always sits at bit 0.
  logic             r_v     [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic             r_c     [STAGES];
  logic             r_amsb  [STAGES];
  logic             r_bmsb  [STAGES];

  logic             w_adv     [STAGES];
  logic             w_src_v   [STAGES];
  logic [WIDTH-1:0] w_src_sum [STAGES];
  logic [WIDTH-1:0] w_src_a   [STAGES];
  logic [WIDTH-1:0] w_src_b   [STAGES];
  logic             w_src_c   [STAGES];
  logic             w_src_am  [STAGES];
  logic             w_src_bm  [STAGES];
  logic [SLICE_W:0] w_res     [STAGES];
  logic [WIDTH-1:0] w_new_sum [STAGES];

  logic [WIDTH-1:0] w_b0;
  logic             w_c0;

`ifdef CLA_PIPE_SUB_EN
  assign w_b0 = in_sub ? ~in_b : in_b;
  assign w_c0 = in_sub | in_cin;
`else
  logic w_unused_sub;
  assign w_unused_sub = in_sub;
  assign w_b0         = in_b;
  assign w_c0         = in_cin;
`endif

  // Two-level lookahead inside each 4-bit group; groups chain on group P/G.
  function automatic logic [SLICE_W:0] cla_slice(
    input logic [SLICE_W-1:0] a,
    input logic [SLICE_W-1:0] b,
    input logic               cin
  );
    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] s;
    logic [3:0]         gp;
    logic [3:0]         gg;
    logic [3:0]         c;
    logic               grp_p;
    logic               grp_g;
    logic               gc;
    p  = a ^ b;
    g  = a & b;
    s  = '0;
    gc = cin;
    for (int j = 0; j < GROUPS; j++) begin
      gp    = p[4*j +: 4];
      gg    = g[4*j +: 4];
      c[0]  = gc;
      c[1]  = gg[0] | (gp[0] & gc);
      c[2]  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc);
      c[3]  = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
            | (gp[2] & gp[1] & gp[0] & gc);
      grp_p = &gp;
      grp_g = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
            | (gp[3] & gp[2] & gp[1] & gg[0]);
      s[4*j +: 4] = gp ^ c;
      gc    = grp_g | (grp_p & gc);
    end
    return {gc, s};
  endfunction

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign w_src_v[k]   = in_valid;
        assign w_src_sum[k] = '0;
        assign w_src_a[k]   = in_a;
        assign w_src_b[k]   = w_b0;
        assign w_src_c[k]   = w_c0;
        assign w_src_am[k]  = in_a[WIDTH-1];
        assign w_src_bm[k]  = w_b0[WIDTH-1];
      end else begin : g_body
        assign w_src_v[k]   = r_v[k-1];
        assign w_src_sum[k] = r_sum[k-1];
        assign w_src_a[k]   = r_a[k-1];
        assign w_src_b[k]   = r_b[k-1];
        assign w_src_c[k]   = r_c[k-1];
        assign w_src_am[k]  = r_amsb[k-1];
        assign w_src_bm[k]  = r_bmsb[k-1];
      end

      assign w_res[k] = cla_slice(w_src_a[k][SLICE_W-1:0],
                                  w_src_b[k][SLICE_W-1:0],
                                  w_src_c[k]);
      // New slice enters from the top; after the last stage the sum is aligned.
      assign w_new_sum[k] = (w_src_sum[k] >> SLICE_W)
                          | (WIDTH'(w_res[k][SLICE_W-1:0]) << (WIDTH - SLICE_W));
    end
  endgenerate

  // Bubble-collapsing advance chain, resolved from the output backwards.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_adv[k] = 1'b0;
    end
    w_adv[LAST] = ~r_v[LAST] | out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      w_adv[k] = ~r_v[k] | w_adv[k+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_v[k]    <= 1'b0;
        r_sum[k]  <= '0;
        r_a[k]    <= '0;
        r_b[k]    <= '0;
        r_c[k]    <= 1'b0;
        r_amsb[k] <= 1'b0;
        r_bmsb[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_v[k] <= w_src_v[k];
          if (w_src_v[k]) begin
            r_sum[k]  <= w_new_sum[k];
            r_a[k]    <= w_src_a[k] >> SLICE_W;
            r_b[k]    <= w_src_b[k] >> SLICE_W;
            r_c[k]    <= w_res[k][SLICE_W];
            r_amsb[k] <= w_src_am[k];
            r_bmsb[k] <= w_src_bm[k];
          end
        end
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_v[LAST];
  assign out_sum   = r_sum[LAST];
  assign out_cout  = r_c[LAST];
  // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
  assign out_ovf   = r_c[LAST] ^ r_sum[LAST][WIDTH-1] ^ r_amsb[LAST] ^ r_bmsb[LAST];

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_pipe_adder
// Description : Self-checking bench for cla_pipe_adder (directed, backpressure,
//               reset, optional subtract, randomized stream vs. a model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 2;
  localparam int N_RAND = 3000;
  localparam longint MODV = longint'(1) << WIDTH;
`ifdef CLA_PIPE_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic             in_sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  res_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference: integer arithmetic on unsigned and signed interpretations.
  function automatic res_t ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic cin, input logic sub);
    longint ua, ub, sa, sb, total, sr;
    res_t   r;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= MODV / 2) ? ua - MODV : ua;
    sb = (ub >= MODV / 2) ? ub - MODV : ub;
    if (SUB_EN && sub) begin
      total  = ua - ub;
      r.cout = (ua >= ub);
      sr     = sa - sb;
    end else begin
      total  = ua + ub + longint'(cin);
      r.cout = (total >= MODV);
      sr     = sa + sb + longint'(cin);
    end
    r.sum = total[WIDTH-1:0];
    r.ovf = (sr >= MODV / 2) || (sr < -(MODV / 2));
    return r;
  endfunction

  // One clock: sample handshake at the falling edge, return 1 after rising edge.
  task automatic step(output bit acc, output bit rel, output res_t got, output bit stall);
    @(negedge clk);
    acc      = in_valid && in_ready;
    rel      = out_valid && out_ready;
    stall    = out_valid && !out_ready;
    got.sum  = out_sum;
    got.cout = out_cout;
    got.ovf  = out_ovf;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %h expected 0", out_sum); end
    n_cmp++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b expected 0", out_cout); end
    n_cmp++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", out_ovf); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] va [3] = '{16'hFFFF, 16'h7FFF, 16'h1234};
    logic [WIDTH-1:0] vb [3] = '{16'h0001, 16'h0001, 16'h0000};
    logic             vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [WIDTH-1:0] es [3] = '{16'h0000, 16'h8000, 16'h1235};
    logic             ec [3] = '{1'b1, 1'b0, 1'b0};
    logic             eo [3] = '{1'b0, 1'b1, 1'b0};
    bit acc, rel, stall;
    res_t got;
    int lat;
    out_ready = 1'b1;
    in_sub    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_cin = vc[i];
      step(acc, rel, got, stall);
      in_valid = 1'b0;
      n_cmp++; if (!acc) begin n_fail++; $display("FAIL dir_accept[%0d]: got 0 expected 1", i); end
      lat = 0;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      n_cmp++; if (lat != STAGES - 1) begin n_fail++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, STAGES - 1); end
      n_cmp++;
      if ({out_sum, out_cout, out_ovf} !== {es[i], ec[i], eo[i]}) begin
        n_fail++;
        $display("FAIL dir_result[%0d]: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                 i, out_sum, out_cout, out_ovf, es[i], ec[i], eo[i]);
      end
      step(acc, rel, got, stall);
    end
  endtask

  task automatic test_backpressure();
    bit acc, rel, stall;
    res_t got;
    int idx = 0;
    int released = 0;
    int cyc = 0;
    logic [WIDTH-1:0] v;
    q.delete();
    out_ready = 1'b0; in_cin = 1'b0; in_sub = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4); v = WIDTH'(idx + 1); in_a = v; in_b = v;
      step(acc, rel, got, stall);
      if (acc) idx++;
    end
    n_cmp++; if (idx != STAGES) begin n_fail++; $display("FAIL bp_accepts: got %0d expected %0d", idx, STAGES); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    while (released < 4 && cyc < 40) begin
      in_valid = (idx < 4); v = WIDTH'(idx + 1); in_a = v; in_b = v;
      step(acc, rel, got, stall);
      if (acc) idx++;
      if (rel) begin
        n_cmp++;
        if (got.sum !== WIDTH'(2 * (released + 1)) || got.cout !== 1'b0 || got.ovf !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_order[%0d]: got sum=%h expected %h", released, got.sum, WIDTH'(2 * (released + 1)));
        end
        released++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (released != 4) begin n_fail++; $display("FAIL bp_released: got %0d expected 4", released); end
  endtask

`ifdef CLA_PIPE_SUB_EN
  task automatic test_sub();
    logic [WIDTH-1:0] va [2] = '{16'h0005, 16'h8000};
    logic [WIDTH-1:0] vb [2] = '{16'h0007, 16'h0001};
    logic [WIDTH-1:0] es [2] = '{16'hFFFE, 16'h7FFF};
    logic             ec [2] = '{1'b0, 1'b1};
    logic             eo [2] = '{1'b0, 1'b1};
    bit acc, rel, stall;
    res_t got;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_a = va[i]; in_b = vb[i]; in_cin = 1'b0; in_sub = 1'b1;
      step(acc, rel, got, stall);
      in_valid = 1'b0; in_sub = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      n_cmp++;
      if ({out_valid, out_sum, out_cout, out_ovf} !== {1'b1, es[i], ec[i], eo[i]}) begin
        n_fail++;
        $display("FAIL sub_result[%0d]: got v=%b sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                 i, out_valid, out_sum, out_cout, out_ovf, es[i], ec[i], eo[i]);
      end
      step(acc, rel, got, stall);
    end
  endtask
`endif

  task automatic test_reset_midflight();
    bit acc, rel, stall;
    res_t got;
    int released = 0;
    out_ready = 1'b1; in_sub = 1'b0; in_cin = 1'b0;
    in_valid = 1'b1; in_a = 16'h0100; in_b = 16'h0200;
    step(acc, rel, got, stall);
    in_valid = 1'b0;
    n_cmp++; if (!acc) begin n_fail++; $display("FAIL rst_mid_accept: got 0 expected 1"); end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_sum, out_cout, out_ovf} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got v=%b sum=%h cout=%b ovf=%b expected all 0",
               out_valid, out_sum, out_cout, out_ovf);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0001;
    step(acc, rel, got, stall);
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(acc, rel, got, stall);
      if (rel) begin
        n_cmp++;
        if (got.sum !== 16'h0002) begin n_fail++; $display("FAIL rst_mid_result: got %h expected 0002", got.sum); end
        released++;
      end
    end
    n_cmp++; if (released != 1) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 1", released); end
  endtask

  task automatic test_random();
    bit acc, rel, stall;
    bit was_stall = 1'b0;
    res_t got, held, exp;
    int sent = 0;
    int got_n = 0;
    int cyc = 0;
    q.delete();
    while (got_n < N_RAND && cyc < 40000) begin
      in_valid  = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
      in_a      = WIDTH'($urandom);
      in_b      = WIDTH'($urandom);
      in_cin    = 1'($urandom);
      in_sub    = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if (was_stall) begin
        n_cmp++;
        if ({out_valid, out_sum, out_cout, out_ovf} !== {1'b1, held.sum, held.cout, held.ovf}) begin
          n_fail++;
          $display("FAIL rand_stall_hold: got v=%b sum=%h expected v=1 sum=%h", out_valid, out_sum, held.sum);
        end
      end
      step(acc, rel, got, stall);
      was_stall = stall;
      held      = got;
      if (rel) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra: got sum=%h expected no result", got.sum);
        end else begin
          exp = q.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL rand_result[%0d]: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                     got_n, got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
          end
        end
        got_n++;
      end
      if (acc) begin
        q.push_back(ref_model(in_a, in_b, in_cin, in_sub));
        sent++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (got_n != N_RAND) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", got_n, N_RAND); end
    n_cmp++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_leftover: got %0d expected 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
`ifdef CLA_PIPE_SUB_EN
    test_sub();
`endif
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
